// File: rtl/game_timer_pkg.sv
// Shared definitions for the game timer: timer states, game-FSM state encodings and
// the professor/time-limit constants used by the timer and its consumers.
package game_timer_pkg;

  localparam int         MAX_TIME     = 120;
  localparam logic [3:0] PROF_PATTERN = 4'b1111;
  // The warning fires one minute before the professor pattern appears.
  localparam logic [3:0] PROF_WARN_PATTERN = PROF_PATTERN - 4'd1;

  typedef enum logic [1:0] {
    ST_STOPPED   = 2'd0,
    ST_RUNNING   = 2'd1,
    ST_SATURATED = 2'd2
  } timer_state_e;

  typedef enum logic [2:0] {
    Q_INI  = 3'd0,
    Q_PLAY = 3'd1,
    Q_PROF = 3'd2,
    Q_WIN  = 3'd3,
    Q_LOSE = 3'd4
  } game_state_e;

  function automatic logic is_prof_warn(input logic [7:0] mins);
    return mins[3:0] == PROF_WARN_PATTERN;
  endfunction

endpackage

// File: rtl/game_timer_bcd_digit_counter.sv
// One decimal digit of the minute display: increments on inc, wraps 9->0 with carry out.
module bcd_digit_counter
  import game_timer_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] digit,
  output logic       carry
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = 4'd0;
    end else if (inc) begin
      digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign carry = inc & ~clr & (digit_q == 4'd9);

endmodule

// File: rtl/game_timer.sv
// Game minute timer: prescaler, run/pause/saturate FSM, binary minute counter with
// professor warning and time-up flags, and a chained BCD copy for the display.
module game_timer
  import game_timer_pkg::*;
#(
  parameter int TICKS_PER_MIN = 100_000_000,
  parameter int MAX_MIN       = 255,
  parameter int LIMIT         = MAX_TIME
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Clear,
  input  logic       Run,
  output logic [7:0] minutes,
  output logic       min_tick,
  output logic       prof_warn,
  output logic       time_up,
  output logic [3:0] bcd_h,
  output logic [3:0] bcd_t,
  output logic [3:0] bcd_o,
  output logic       running
);

  localparam int              PW         = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICKS_PER_MIN - 1);
  localparam logic [7:0]      MIN_LAST   = 8'(MAX_MIN - 1);

  timer_state_e  state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    minutes_q, minutes_d;
  logic          min_tick_q, min_tick_d;
  logic          prof_warn_q, prof_warn_d;
  logic          time_up_q, time_up_d;
  logic          running_q, running_d;

  logic tick;
  logic carry_o, carry_t, carry_h;

  // A tick needs the full prescaler period spent in RUNNING with Run held high.
  assign tick = (state_q == ST_RUNNING) & Run & ~Clear & (presc_q == PRESC_LAST);

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    minutes_d = minutes_q;
    if (Clear) begin
      state_d   = ST_STOPPED;
      presc_d   = '0;
      minutes_d = 8'd0;
    end else begin
      case (state_q)
        ST_STOPPED: begin
          if (Run) state_d = ST_RUNNING;
        end
        ST_RUNNING: begin
          if (!Run) begin
            state_d = ST_STOPPED;
          end else if (tick) begin
            presc_d   = '0;
            minutes_d = minutes_q + 8'd1;
            // A hundreds carry would wrap the display, so it saturates as well.
            if (minutes_q == MIN_LAST || carry_h) state_d = ST_SATURATED;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
    min_tick_d  = tick;
    prof_warn_d = is_prof_warn(minutes_d);
    time_up_d   = int'({24'd0, minutes_d}) >= LIMIT;
    running_d   = (state_d == ST_RUNNING);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_STOPPED;
      presc_q     <= '0;
      minutes_q   <= 8'd0;
      min_tick_q  <= 1'b0;
      prof_warn_q <= 1'b0;
      time_up_q   <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      minutes_q   <= minutes_d;
      min_tick_q  <= min_tick_d;
      prof_warn_q <= prof_warn_d;
      time_up_q   <= time_up_d;
      running_q   <= running_d;
    end
  end

  bcd_digit_counter u_ones (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .inc     (tick),
    .clr     (Clear),
    .digit   (bcd_o),
    .carry   (carry_o)
  );

  bcd_digit_counter u_tens (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .inc     (carry_o),
    .clr     (Clear),
    .digit   (bcd_t),
    .carry   (carry_t)
  );

  bcd_digit_counter u_hund (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .inc     (carry_t),
    .clr     (Clear),
    .digit   (bcd_h),
    .carry   (carry_h)
  );

  assign minutes   = minutes_q;
  assign min_tick  = min_tick_q;
  assign prof_warn = prof_warn_q;
  assign time_up   = time_up_q;
  assign running   = running_q;

endmodule
